// File: rtl/sd4_mac_pkg.sv
// rtl/sd4_mac_pkg.sv - shared word width, zero constant and sequencer state encoding
package sd4_mac_pkg;

    localparam int PSUM_W = 16;
    localparam logic [PSUM_W-1:0] PSUM_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/psum_tag_pipe.sv
// rtl/psum_tag_pipe.sv - PE_LAT-deep {valid, addr} shift register with in-flight address match
module psum_tag_pipe
    import sd4_mac_pkg::*;
#(
    parameter int AW     = 4,
    parameter int PE_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [AW-1:0] query_addr,
    output logic          last_valid,
    output logic [AW-1:0] last_addr,
    output logic          hazard,
    output logic          any_valid
);

    logic [PE_LAT-1:0] valid_q;
    logic [AW-1:0]     addr_q [PE_LAT];

    // Shifts unconditionally; a cycle without push inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < PE_LAT; i++) addr_q[i] <= '0;
        end else begin
            valid_q[0] <= push;
            addr_q[0]  <= push_addr;
            for (int i = 1; i < PE_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PE_LAT; i++) begin
            if (valid_q[i] && (addr_q[i] == query_addr)) hazard = 1'b1;
        end
    end

    assign last_valid = valid_q[PE_LAT-1];
    assign last_addr  = addr_q[PE_LAT-1];
    assign any_valid  = |valid_q;

endmodule

// File: rtl/psum_accum_ctrl.sv
// rtl/psum_accum_ctrl.sv - psum buffer and pass sequencer around PE_row with result streaming
module psum_accum_ctrl
    import sd4_mac_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int PE_LAT = 2,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       num_out,
    input  logic [PASS_W-1:0] num_pass,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PSUM_W-1:0] psum_o,
    input  logic [PSUM_W-1:0] pe_out_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PSUM_W-1:0] res_data,
    output logic [AW-1:0]     res_addr,
    output logic              done
);

    state_t            state, next_state;
    logic [AW:0]       num_out_q, addr, rd;
    logic [PASS_W-1:0] num_pass_q, pass;
    logic [PSUM_W-1:0] mem [DEPTH];

    logic          hazard, tag_valid, tag_any;
    logic [AW-1:0] tag_addr;
    logic          issue, start_ok, addr_last, pass_last, rd_last;

    assign start_ok  = start && (num_out != '0) && (num_pass != '0);
    assign addr_last = (addr == num_out_q - (AW+1)'(1));
    assign rd_last   = (rd == num_out_q - (AW+1)'(1));
    assign pass_last = (pass == num_pass_q - PASS_W'(1));
    assign issue     = (state == ST_RUN) && in_valid && !hazard;

    psum_tag_pipe #(.AW(AW), .PE_LAT(PE_LAT)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (issue),
        .push_addr  (addr[AW-1:0]),
        .query_addr (addr[AW-1:0]),
        .last_valid (tag_valid),
        .last_addr  (tag_addr),
        .hazard     (hazard),
        .any_valid  (tag_any)
    );

    // Contents are don't-care after reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && tag_valid) mem[tag_addr] <= pe_out_i;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_out_q  <= '0;
            num_pass_q <= '0;
            addr       <= '0;
            pass       <= '0;
            rd         <= '0;
        end else begin
            if ((state == ST_IDLE) && start_ok) begin
                num_out_q  <= num_out;
                num_pass_q <= num_pass;
                addr       <= '0;
                pass       <= '0;
            end
            if (issue) begin
                if (addr_last) begin
                    addr <= '0;
                    pass <= pass + PASS_W'(1);
                end else begin
                    addr <= addr + (AW+1)'(1);
                end
            end
            if (state == ST_DRAIN) rd <= '0;
            if ((state == ST_FLUSH) && res_ready) rd <= rd + (AW+1)'(1);
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        in_ready   = 1'b0;
        psum_o     = PSUM_ZERO;
        res_valid  = 1'b0;
        res_data   = PSUM_ZERO;
        res_addr   = '0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) next_state = ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !hazard;
                if (issue) begin
                    psum_o = (pass == '0) ? PSUM_ZERO : mem[addr[AW-1:0]];
                    if (addr_last && pass_last) next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!tag_any) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_data  = mem[rd[AW-1:0]];
                res_addr  = rd[AW-1:0];
                if (res_ready && rd_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb/tb_psum_accum_ctrl.sv - randomized self-checking bench with PE_row modelled as psum + 1
module tb_psum_accum_ctrl;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int PE_LAT = 2;
    localparam int PASS_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       num_out;
    logic [PASS_W-1:0] num_pass;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       psum_o;
    logic [15:0]       pe_out_i;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_data;
    logic [AW-1:0]     res_addr;
    logic              done;

    int errors = 0;
    int checks = 0;

    psum_accum_ctrl #(.DEPTH(DEPTH), .AW(AW), .PE_LAT(PE_LAT), .PASS_W(PASS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_out   (num_out),
        .num_pass  (num_pass),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_o    (psum_o),
        .pe_out_i  (pe_out_i),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_addr  (res_addr),
        .done      (done)
    );

    always #5 clk = ~clk;

    // PE_row: psum sampled in the issue cycle, psum + 1 visible PE_LAT cycles later.
    logic [15:0] pe_pipe [PE_LAT];
    always @(posedge clk) begin
        pe_pipe[0] <= psum_o + 16'd1;
        for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
    assign pe_out_i = pe_pipe[PE_LAT-1];

    task automatic run_tile(input int no, input int np, input int vmode, input int rmode,
                            input bit flush_start, input string tag);
        int exp_mem [DEPTH];
        int last_iss [DEPTH];
        int a, issued, total, rd, cyc, done_cnt, limit;
        bit fin, prev_stall, exp_rdy;
        logic [15:0] prev_data;
        logic [AW-1:0] prev_addr;
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i]  = 0;
            last_iss[i] = -100;
        end
        a = 0; issued = 0; total = no * np; rd = 0; done_cnt = 0;
        fin = 0; prev_stall = 0; prev_data = '0; prev_addr = '0;
        limit = total * 4 + 200;

        start    = 1'b1;
        num_out  = no[AW:0];
        num_pass = np[PASS_W-1:0];
        in_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_before_start: busy=%b required 0", tag, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;

        while (!fin && cyc < limit) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc % 3) != 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            case (rmode)
                0:       res_ready = 1'b1;
                1:       res_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);

            if (issued < total) begin
                exp_rdy = (cyc >= last_iss[a] + PE_LAT + 1);
                checks++;
                if (in_ready !== exp_rdy || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s in_ready cyc=%0d: in_ready=%b busy=%b required in_ready=%b busy=1",
                             tag, cyc, in_ready, busy, exp_rdy);
                end
                if (in_valid && in_ready) begin
                    checks++;
                    if (psum_o !== 16'(exp_mem[a])) begin
                        errors++;
                        $display("FAIL %s psum_issue addr=%0d: psum_o=%0d required %0d",
                                 tag, a, psum_o, exp_mem[a]);
                    end
                    exp_mem[a]  = exp_mem[a] + 1;
                    last_iss[a] = cyc;
                    a = (a + 1) % no;
                    issued++;
                end else begin
                    checks++;
                    if (psum_o !== 16'h0000) begin
                        errors++;
                        $display("FAIL %s psum_idle cyc=%0d: psum_o=%h required 0000", tag, cyc, psum_o);
                    end
                end
            end else begin
                checks++;
                if (in_ready !== 1'b0 || psum_o !== 16'h0000) begin
                    errors++;
                    $display("FAIL %s quiet_after_issue: in_ready=%b psum_o=%h required 0/0000",
                             tag, in_ready, psum_o);
                end
            end

            if (res_valid) begin
                checks++;
                if (issued != total || rd >= no) begin
                    errors++;
                    $display("FAIL %s result_window: issued=%0d rd=%0d required issued=%0d rd<%0d",
                             tag, issued, rd, total, no);
                end
                checks++;
                if (res_addr !== rd[AW-1:0] || res_data !== 16'(np)) begin
                    errors++;
                    $display("FAIL %s result: addr=%0d data=%0d required addr=%0d data=%0d",
                             tag, res_addr, res_data, rd, np);
                end
                if (prev_stall) begin
                    checks++;
                    if (res_data !== prev_data || res_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL %s stall_stable: addr=%0d data=%0d required addr=%0d data=%0d",
                                 tag, res_addr, res_data, prev_addr, prev_data);
                    end
                end
                prev_stall = !res_ready;
                prev_data  = res_data;
                prev_addr  = res_addr;
                if (res_ready) rd++;
                if (flush_start) begin
                    start    = 1'b1;
                    num_out  = 5'd1;
                    num_pass = 8'd1;
                end
            end else begin
                prev_stall = 1'b0;
            end

            if (done) begin
                done_cnt++;
                fin = 1;
                checks++;
                if (rd != no) begin
                    errors++;
                    $display("FAIL %s done_count: results=%0d required %0d", tag, rd, no);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end

        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_seen: pulses=%0d required 1 (cycles=%0d)", tag, done_cnt, cyc);
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: busy=%b done=%b required 0/0", tag, busy, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy, in_ready, psum_o, res_valid, res_data, res_addr, done} !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: busy=%b in_ready=%b psum_o=%h res_valid=%b res_data=%h res_addr=%h done=%b required all 0",
                     tag, busy, in_ready, psum_o, res_valid, res_data, res_addr, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
        num_out = 5'd4; num_pass = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        int n;
        seen = 0; n = 0;
        start = 1'b1; num_out = 5'd4; num_pass = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
        while (seen < 6 && n < 50) begin
            @(negedge clk);
            if (in_valid && in_ready) seen++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (seen != 6) begin
            errors++;
            $display("FAIL mid_run_issues: issued=%0d required 6", seen);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_run_reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d: busy=%b res_valid=%b required 0/0", i, busy, res_valid);
            end
        end
        @(posedge clk); #1;
        run_tile(2, 2, 0, 0, 0, "after_mid_reset");
    endtask

    task automatic test_ignored_start();
        for (int k = 0; k < 2; k++) begin
            start    = 1'b1;
            num_out  = (k == 0) ? 5'd4 : 5'd0;
            num_pass = (k == 0) ? 8'd0 : 8'd3;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_start k=%0d: busy=%b required 0", k, busy);
                end
            end
            @(posedge clk); #1;
        end
        run_tile(4, 3, 0, 2, 1, "start_in_flush");
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            run_tile(int'($urandom_range(1, DEPTH)), int'($urandom_range(1, 5)), 2, 2, 0, "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        num_out = '0; num_pass = '0;
        test_reset();
        run_tile(4, 3, 0, 0, 0, "basic");
        run_tile(1, 4, 0, 0, 0, "single_position");
        run_tile(4, 3, 0, 1, 0, "res_backpressure");
        run_tile(4, 3, 1, 0, 0, "in_gaps");
        test_reset_mid_run();
        test_ignored_start();
        run_tile(2, 3, 0, 0, 0, "num_out_eq_lat");
        run_tile(DEPTH, 255, 0, 0, 0, "full_depth_max_pass");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
